rr_arbiter_n: RTL and testbench



---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 38 +++
 rtl/rr_arbiter_n.sv | 98 +++++++++
 tb/tb_rr_arbiter_n.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared limits, width helper and hold-counter type for the round-robin arbiter
package arb_pkg;

    localparam int ARB_MAX_REQ  = 32;
    localparam int ARB_MAX_HOLD = 255;

    // Widest hold counter any legal MAX_HOLD can need.
    typedef logic [$clog2(ARB_MAX_HOLD+1)-1:0] arb_hold_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder: first set req bit at or after start, with wrap
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    logic [2*N_REQ-1:0] w_req2;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W:0]     w_sum;

    // Rotating the doubled vector puts index start at bit 0.
    assign w_req2 = {req, req};
    assign w_rot  = N_REQ'(w_req2 >> start);
    assign any    = |req;

    always_comb begin
        w_sum = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_sum = {1'b0, start} + (IDX_W+1)'(i);
            end
        end
        if (w_sum >= (IDX_W+1)'(N_REQ)) begin
            w_sum = w_sum - (IDX_W+1)'(N_REQ);
        end
        pick_idx = w_sum[IDX_W-1:0];
        pick     = any ? (N_REQ'(1) << pick_idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - N-way round-robin arbiter with burst hold and registered one-hot/encoded grant
// Optional owner lock input when ARB_LOCK_EN is defined.
module rr_arbiter_n
    import arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 1,
    localparam int IDX_W    = clog2_min1(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] request,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    if (N_REQ < 2 || N_REQ > ARB_MAX_REQ) begin : g_bad_nreq
        $error("rr_arbiter_n: N_REQ must be in 2..32");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > ARB_MAX_HOLD) begin : g_bad_hold
        $error("rr_arbiter_n: MAX_HOLD must be in 1..255");
    end

    logic [N_REQ-1:0]  r_grant;
    logic              r_grant_valid;
    logic [IDX_W-1:0]  r_grant_idx;
    logic [IDX_W-1:0]  r_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [IDX_W-1:0]  w_start;
    logic [N_REQ-1:0]  w_pick;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_any;
    logic              w_owner_req;
    logic              w_others;
    logic              w_hold_ok;
    logic              w_lock_hold;

    assign w_start = (r_ptr == IDX_W'(N_REQ - 1)) ? '0 : r_ptr + 1'b1;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req      (request),
        .start    (w_start),
        .pick     (w_pick),
        .pick_idx (w_pick_idx),
        .any      (w_any)
    );

    // r_grant is one-hot on the owner whenever valid, so it doubles as the owner mask.
    assign w_owner_req = r_grant_valid && |(request & r_grant);
    assign w_others    = |(request & ~r_grant);
    assign w_hold_ok   = w_owner_req && ((r_hold_cnt < HOLD_W'(MAX_HOLD)) || !w_others);

`ifdef ARB_LOCK_EN
    assign w_lock_hold = lock && w_owner_req;
`else
    assign w_lock_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_ptr         <= IDX_W'(N_REQ - 1);
            r_hold_cnt    <= '0;
        end else if (w_lock_hold) begin
            r_hold_cnt <= r_hold_cnt;
        end else if (w_hold_ok) begin
            if (r_hold_cnt != HOLD_W'(MAX_HOLD)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end else if (w_any) begin
            r_grant       <= w_pick;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= w_pick_idx;
            r_ptr         <= w_pick_idx;
            r_hold_cnt    <= HOLD_W'(1);
        end else begin
            // Pointer is kept so priority resumes after the last owner.
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_hold_cnt    <= '0;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb/tb_rr_arbiter_n.sv - directed table-driven bench for rr_arbiter_n (MAX_HOLD=1 and MAX_HOLD=3 instances)
module tb_rr_arbiter_n;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic [3:0] request_h3;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] grant_h3;
    logic       grant_valid_h3;
    logic [1:0] grant_idx_h3;
`ifdef ARB_LOCK_EN
    logic       lock;
    logic       lock_h3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_arbiter_n #(.N_REQ(4), .MAX_HOLD(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
`ifdef ARB_LOCK_EN
        .lock        (lock),
`endif
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    rr_arbiter_n #(.N_REQ(4), .MAX_HOLD(3)) dut_h3 (
        .clk         (clk),
        .reset       (reset),
        .request     (request_h3),
`ifdef ARB_LOCK_EN
        .lock        (lock_h3),
`endif
        .grant       (grant_h3),
        .grant_valid (grant_valid_h3),
        .grant_idx   (grant_idx_h3)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] g;
        logic       v;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [3:0] g, input logic v, input logic [1:0] idx);
        check({tag, " grant"}, 32'(grant), 32'(g));
        check({tag, " valid"}, 32'(grant_valid), 32'(v));
        check({tag, " idx"}, 32'(grant_idx), 32'(idx));
        check({tag, " onehot0"}, 32'($onehot0(grant)), 32'd1);
    endtask

    task automatic check_h3(input string tag, input logic [3:0] g, input logic [1:0] idx);
        check({tag, " h3 grant"}, 32'(grant_h3), 32'(g));
        check({tag, " h3 valid"}, 32'(grant_valid_h3), 32'(g != 4'b0000));
        check({tag, " h3 idx"}, 32'(grant_idx_h3), 32'(idx));
    endtask

    initial begin
        reset      = 1'b0;
        request    = 4'b0000;
        request_h3 = 4'b0000;
`ifdef ARB_LOCK_EN
        lock       = 1'b0;
        lock_h3    = 1'b0;
`endif

        // Reset held with all requesting, then release.
        tbl.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0});
        // Full contention rotation.
        tbl.push_back('{1'b1, 4'b1111, 4'b0010, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 4'b1111, 4'b0100, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000, 1'b1, 2'd3});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0});
        // Single requester held for five cycles.
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0});
        // Wrap from owner 3, idle, then search after ptr=0.
        tbl.push_back('{1'b1, 4'b1000, 4'b1000, 1'b1, 2'd3});
        tbl.push_back('{1'b1, 4'b1001, 4'b0001, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b1, 4'b0110, 4'b0010, 1'b1, 2'd1});
        // Owner drops its request.
        tbl.push_back('{1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0});
        // Mid-operation reset restarts the search at index 0.
        tbl.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 4'b1010, 4'b1000, 1'b1, 2'd3});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            reset   = tbl[i].rst_n;
            request = tbl[i].req;
            tick();
            check_main($sformatf("vec%0d", i), tbl[i].g, tbl[i].v, tbl[i].idx);
        end

        // Burst hold on the MAX_HOLD=3 instance; its ptr was reset to 3.
        begin
            logic [3:0] exp_seq [7];
            exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
            request_h3 = 4'b0011;
            for (int i = 0; i < 7; i++) begin
                tick();
                check_h3($sformatf("burst%0d", i), exp_seq[i], (exp_seq[i] == 4'b0010) ? 2'd1 : 2'd0);
            end
        end
        request_h3 = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_h3($sformatf("alone%0d", i), 4'b0001, 2'd0);
        end
        // Saturated hold count lets a newcomer in at the next edge.
        request_h3 = 4'b0101;
        tick();
        check_h3("sat_switch", 4'b0100, 2'd2);
        request_h3 = 4'b0000;
        tick();
        check_h3("h3_idle", 4'b0000, 2'd0);

`ifdef ARB_LOCK_EN
        reset   = 1'b0;
        request = 4'b0000;
        tick();
        reset   = 1'b1;
        request = 4'b0011;
        tick();
        check_main("lock_start", 4'b0001, 1'b1, 2'd0);
        lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_main($sformatf("locked%0d", i), 4'b0001, 1'b1, 2'd0);
        end
        lock = 1'b0;
        tick();
        check_main("unlock", 4'b0010, 1'b1, 2'd1);
        tick();
        check_main("relock_owner0", 4'b0001, 1'b1, 2'd0);
        lock    = 1'b1;
        request = 4'b0010;
        tick();
        check_main("lock_drop", 4'b0010, 1'b1, 2'd1);
        lock    = 1'b0;
        request = 4'b0000;
        tick();
        check_main("lock_idle", 4'b0000, 1'b0, 2'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
